imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 129 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes the immediate at the input, then passes it
// through a one-deep output register fronted by a skid entry so ready_out stays registered.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [31:0]          instruction_in,
    input  logic [2:0]           imm_select_in,
    input  logic [TAG_W-1:0]     tag_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 flush_in,
    output logic [XLEN-1:0]      imm_out,
    output logic [2:0]           imm_type_out,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 illegal_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [ERR_CNT_W-1:0] err_count_out
);
    localparam logic [2:0] SEL_ILLEGAL = 3'b111;
    localparam int         PAY_W       = XLEN + 3 + TAG_W + 1;

    logic [XLEN-1:0]      imm_dec;
    logic [XLEN-1:0]      sh_imm;
    logic                 illegal_dec;
    logic [PAY_W-1:0]     in_pay;

    logic                 main_valid_q, main_valid_d;
    logic [PAY_W-1:0]     main_pay_q, main_pay_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [PAY_W-1:0]     skid_pay_q, skid_pay_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 up_xfer;
    logic                 down_xfer;

    // Shift amounts are 6 bits wide only on RV64.
    generate
        if (XLEN == 64) begin : g_sh64
            assign sh_imm = XLEN'(instruction_in[25:20]);
        end else begin : g_sh32
            assign sh_imm = XLEN'(instruction_in[24:20]);
        end
    endgenerate

    always_comb begin
        imm_dec     = '0;
        illegal_dec = 1'b0;
        case (imm_select_in)
            3'b000: imm_dec = XLEN'($signed(instruction_in[31:20]));
            3'b001: imm_dec = XLEN'($signed({instruction_in[31:25], instruction_in[11:7]}));
            3'b010: imm_dec = XLEN'($signed({instruction_in[31], instruction_in[7],
                                              instruction_in[30:25], instruction_in[11:8], 1'b0}));
            3'b011: imm_dec = XLEN'($signed({instruction_in[31], instruction_in[19:12],
                                              instruction_in[20], instruction_in[30:21], 1'b0}));
            3'b100: imm_dec = XLEN'($signed({instruction_in[31:12], 12'b0}));
            3'b101: imm_dec = XLEN'(instruction_in[19:15]);
            3'b110: imm_dec = sh_imm;
            default: begin
                imm_dec     = '0;
                illegal_dec = 1'b1;
            end
        endcase
    end

    assign in_pay    = {imm_dec, imm_select_in, tag_in, illegal_dec};
    assign ready_out = ~skid_valid_q;
    assign up_xfer   = valid_in & ~skid_valid_q;
    assign down_xfer = main_valid_q & ready_in;

    // The skid entry is only filled while it is empty, so it never competes with an input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_pay_d   = main_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;
        if (flush_in) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (down_xfer) begin
                main_pay_d   = skid_pay_q;
                skid_valid_d = 1'b0;
            end
        end else if (up_xfer) begin
            if (!main_valid_q || down_xfer) begin
                main_pay_d   = in_pay;
                main_valid_d = 1'b1;
            end else begin
                skid_pay_d   = in_pay;
                skid_valid_d = 1'b1;
            end
        end else if (down_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    // Illegal selects are counted on acceptance, even when a flush discards the item.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (up_xfer && imm_select_in == SEL_ILLEGAL && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            main_valid_q <= 1'b0;
            main_pay_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pay_q   <= main_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign {imm_out, imm_type_out, tag_out, illegal_out} = main_pay_q;
    assign valid_out     = main_valid_q;
    assign err_count_out = err_cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an RV32 instance and an RV64 instance with a 2-bit
// error counter share one stimulus stream and are checked against a queue-level model.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic [2:0]  sel;
    logic [4:0]  tag;
    logic        valid_in, flush, ready_in;

    logic        a_ready, a_type_dummy, a_illegal, a_valid;
    logic [31:0] a_imm;
    logic [2:0]  a_type;
    logic [4:0]  a_tag;
    logic [7:0]  a_err;
    logic        b_ready, b_illegal, b_valid;
    logic [63:0] b_imm;
    logic [2:0]  b_type;
    logic [4:0]  b_tag;
    logic [1:0]  b_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  sel;
        logic [4:0]  tag;
    } item_t;
    item_t q[$];
    int err_a_m = 0;
    int err_b_m = 0;

    always #5 clk = ~clk;
    assign a_type_dummy = 1'b0;

    imm_gen_pipe dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .instruction_in(instruction), .imm_select_in(sel),
        .tag_in(tag), .valid_in(valid_in), .ready_out(a_ready), .flush_in(flush),
        .imm_out(a_imm), .imm_type_out(a_type), .tag_out(a_tag), .illegal_out(a_illegal),
        .valid_out(a_valid), .ready_in(ready_in), .err_count_out(a_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ERR_CNT_W(2)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .instruction_in(instruction), .imm_select_in(sel),
        .tag_in(tag), .valid_in(valid_in), .ready_out(b_ready), .flush_in(flush),
        .imm_out(b_imm), .imm_type_out(b_type), .tag_out(b_tag), .illegal_out(b_illegal),
        .valid_out(b_valid), .ready_in(ready_in), .err_count_out(b_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] f, input int w);
        if (f[w-1]) return f - (64'd1 << w);
        return f;
    endfunction

    // Immediate fields assembled arithmetically from the instruction bit positions.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input bit x64);
        logic [63:0] l, r;
        l = 64'(i);
        case (s)
            3'd0: r = sext(l >> 20, 12);
            3'd1: r = sext(((l >> 25) << 5) | ((l >> 7) & 31), 12);
            3'd2: r = sext((((l >> 31) & 1) << 12) | (((l >> 7) & 1) << 11)
                           | (((l >> 25) & 63) << 5) | (((l >> 8) & 15) << 1), 13);
            3'd3: r = sext((((l >> 31) & 1) << 20) | (((l >> 12) & 255) << 12)
                           | (((l >> 20) & 1) << 11) | (((l >> 21) & 1023) << 1), 21);
            3'd4: r = sext(l & 64'hFFFF_F000, 32);
            3'd5: r = (l >> 15) & 31;
            3'd6: r = x64 ? ((l >> 20) & 63) : ((l >> 20) & 31);
            default: r = 64'd0;
        endcase
        if (!x64) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    // Two-entry FIFO model: pop on downstream ready, push when fewer than two are held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            err_a_m = 0;
            err_b_m = 0;
        end else begin
            int  n;
            bit  acc;
            n   = q.size();
            acc = valid_in && (n < 2);
            if (acc && sel == 3'b111) begin
                if (err_a_m < 255) err_a_m++;
                if (err_b_m < 3) err_b_m++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (n > 0 && ready_in) void'(q.pop_front());
                if (acc) q.push_back('{ins: instruction, sel: sel, tag: tag});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid_a", 64'(a_valid), 64'd0);
            check("rst_ready_a", 64'(a_ready), 64'd1);
            check("rst_err_a", 64'(a_err), 64'd0);
            check("rst_valid_b", 64'(b_valid), 64'd0);
            check("rst_err_b", 64'(b_err), 64'd0);
        end else begin
            check("valid_a", 64'(a_valid), 64'(q.size() > 0));
            check("valid_b", 64'(b_valid), 64'(q.size() > 0));
            check("ready_a", 64'(a_ready), 64'(q.size() < 2));
            check("ready_b", 64'(b_ready), 64'(q.size() < 2));
            check("err_a", 64'(a_err), 64'(err_a_m));
            check("err_b", 64'(b_err), 64'(err_b_m));
            if (q.size() > 0) begin
                check("imm_a", 64'(a_imm), ref_imm(q[0].ins, q[0].sel, 1'b0));
                check("imm_b", b_imm, ref_imm(q[0].ins, q[0].sel, 1'b1));
                check("type_a", 64'(a_type), 64'(q[0].sel));
                check("type_b", 64'(b_type), 64'(q[0].sel));
                check("tag_a", 64'(a_tag), 64'(q[0].tag));
                check("tag_b", 64'(b_tag), 64'(q[0].tag));
                check("illegal_a", 64'(a_illegal), 64'(q[0].sel == 3'b111));
                check("illegal_b", 64'(b_illegal), 64'(q[0].sel == 3'b111));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] s,
                        input logic [4:0] t, input logic rdy, input logic fl);
        @(negedge clk);
        valid_in = v; instruction = ins; sel = s; tag = t; ready_in = rdy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_valid"}, 64'({a_valid, b_valid}), 64'd0);
        check({pfx, "_ready"}, 64'({a_ready, b_ready}), 64'd3);
        check({pfx, "_err"}, 64'({a_err, b_err}), 64'd0);
        check({pfx, "_imm_a"}, 64'(a_imm), 64'd0);
        check({pfx, "_imm_b"}, b_imm, 64'd0);
        check({pfx, "_type_tag"}, 64'({a_type, a_tag, b_type, b_tag}), 64'd0);
        check({pfx, "_illegal"}, 64'({a_illegal, b_illegal}), 64'd0);
    endtask

    logic [31:0] vec [16] = '{
        32'hFFF0_0093, 32'h0010_0113, 32'hFE11_2E23, 32'h0020_A423,
        32'h8000_0063, 32'h7E00_0FE3, 32'h8000_006F, 32'h7FFF_F0EF,
        32'h8000_02B7, 32'h1234_5037, 32'h000F_8073, 32'h0008_0073,
        32'h03F0_0013, 32'h4010_5013, 32'hDEAD_BEEF, 32'h0000_0000
    };
    int e0;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; instruction = '0; sel = '0; tag = '0;
        flush = 1'b0; ready_in = 1'b1;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 0);

        // Illegal selects: zero immediate, flagged, counter saturating on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h1234_5678 + i, 3'b111, 5'(i), 1, 0);
            check("sat_err_b", 64'(b_err), 64'(exp_sat[i]));
            check("sat_err_a", 64'(a_err), 64'(i + 1));
            check("sat_illegal", 64'({a_valid, a_illegal, b_illegal}), 64'd7);
            check("sat_imm", b_imm | 64'(a_imm), 64'd0);
        end

        step(1, 32'hFFF0_0093, 3'b000, 5'd3, 1, 0);
        check("itype_valid", 64'(a_valid), 64'd1);
        check("itype_imm", 64'(a_imm), 64'hFFFF_FFFF);
        check("itype_tag", 64'(a_tag), 64'd3);
        check("itype_illegal", 64'(a_illegal), 64'd0);

        step(1, 32'h8000_02B7, 3'b100, 5'd1, 1, 0);
        check("utype_imm_b", b_imm, 64'hFFFF_FFFF_8000_0000);
        check("utype_imm_a", 64'(a_imm), 64'h8000_0000);
        step(1, 32'h03F0_0013, 3'b110, 5'd2, 1, 0);
        check("sh_imm_b", b_imm, 64'h3F);
        check("sh_imm_a", 64'(a_imm), 64'h1F);
        step(1, 32'hFE11_2E23, 3'b001, 5'd4, 1, 0);
        check("stype_imm_a", 64'(a_imm), 64'hFFFF_FFFC);

        // Every format over a mixed valid/ready pattern to exercise the skid entry.
        for (int i = 0; i < 32; i++) begin
            step(logic'(i % 4 != 3), vec[i % 16], 3'(i % 8), 5'(i), logic'(i % 3 != 0), 0);
        end
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Backpressure: A held while B lands in the skid entry, then both drain in order.
        step(1, 32'h0010_0113, 3'b000, 5'd10, 0, 0);
        step(1, 32'h0020_0193, 3'b000, 5'd11, 0, 0);
        check("bp_ready_low", 64'(a_ready), 64'd0);
        check("bp_hold_tag", 64'(a_tag), 64'd10);
        step(1, 32'h0030_0213, 3'b000, 5'd12, 0, 0);
        check("bp_still_a", 64'({a_tag, a_imm}), 64'({5'd10, 32'd1}));
        step(0, 0, 0, 0, 1, 0);
        check("bp_then_b", 64'({a_valid, a_tag}), 64'({1'b1, 5'd11}));
        check("bp_ready_high", 64'(a_ready), 64'd1);
        step(0, 0, 0, 0, 1, 0);

        // Flush with both entries full, then flush of an accepted illegal item.
        step(1, 32'h0010_0113, 3'b000, 5'd20, 0, 0);
        step(1, 32'h0020_0193, 3'b001, 5'd21, 0, 0);
        e0 = err_a_m;
        step(1, 32'h0030_0213, 3'b000, 5'd22, 0, 1);
        check("flush_valid", 64'({a_valid, b_valid}), 64'd0);
        check("flush_ready", 64'({a_ready, b_ready}), 64'd3);
        check("flush_err_same", 64'(a_err), 64'(e0));
        step(1, 32'h0040_0293, 3'b111, 5'd23, 1, 1);
        check("flush_illegal_counted", 64'(a_err), 64'(e0 + 1));
        check("flush_illegal_dropped", 64'(a_valid), 64'd0);
        step(0, 0, 0, 0, 1, 0);

        // Asynchronous reset between edges with both entries occupied.
        step(1, 32'hFFF0_0093, 3'b000, 5'd30, 0, 0);
        step(1, 32'h8000_02B7, 3'b100, 5'd31, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h8000_006F, 3'b011, 5'd7, 1, 0);
        check("post_rst_tag", 64'({a_valid, a_tag}), 64'({1'b1, 5'd7}));
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
